// File: rtl/gng_scale_fifo_if.sv
// Output stream bundle of gng_scale_fifo: scaled samples toward DAC or DMA logic.
interface gng_scale_fifo_if;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/gng_scale_fifo.sv
// Gaussian noise generator back end.
// Stage 1 scales each incoming s<16,11> sample by a u<16,14> gain. The scaling
// rounds half toward +inf and saturates to 16 bits. Stage 2 buffers the result
// in a first-word-fall-through FIFO. The generator clock enable is throttled
// early enough that samples still in flight upstream always find space.
module gng_scale_fifo #(
    parameter int DEPTH = 16,
    parameter int SLACK = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic [15:0]              gain,
    output logic                     ce,
    input  logic                     valid_in,
    input  logic [15:0]              data_in,
    gng_scale_fifo_if.master         m,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int LW1 = LW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_LEVEL  = LW'(1);
    localparam logic [AW-1:0] ONE_PTR    = AW'(1);
    // Committed occupancy below this keeps more than SLACK entries free
    localparam logic [LW:0]   CE_LIMIT   = LW1'(DEPTH - SLACK);

    // Clamp a rounded product into the signed 16-bit range
    function automatic logic [15:0] sat16(input logic signed [32:0] v);
        logic [15:0] r;
        if (v > 33'sd32767) begin
            r = 16'h7FFF;
        end else if (v < -33'sd32768) begin
            r = 16'h8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    logic signed [32:0] sample_s, gain_s, prod_s, round_s;
    logic [15:0]        scaled_s;

    logic               v1_r;
    logic [15:0]        d1_r;

    logic [15:0]        mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]      level_r, level_nxt_s;
    logic               m_valid_r, ce_r, overflow_r;
    logic               full_s, pop_s, push_s, drop_s, ce_nxt_s;
    logic [LW:0]        committed_s;

    // Signed multiply by the zero-extended gain, then round half up at bit 13
    always_comb begin
        sample_s = $signed({{17{data_in[15]}}, data_in});
        gain_s   = $signed({17'd0, gain});
        prod_s   = sample_s * gain_s;
        round_s  = (prod_s + 33'sd8192) >>> 5'd14;
        scaled_s = sat16(round_s);
    end

    // Stage-1 register: always captures valid_in regardless of ce
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_r <= 1'b0;
            d1_r <= 16'h0000;
        end else begin
            v1_r <= valid_in;
            d1_r <= scaled_s;
        end
    end

    // FIFO handshake decode, next occupancy and generator throttle decision
    always_comb begin
        full_s      = (level_r == FULL_LEVEL);
        pop_s       = m_valid_r & m.m_ready;
        push_s      = v1_r & (~full_s | pop_s);
        drop_s      = v1_r & full_s & ~pop_s;
        level_nxt_s = level_r;
        if (push_s && !pop_s) begin
            level_nxt_s = level_r + ONE_LEVEL;
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_r - ONE_LEVEL;
        end else begin
            level_nxt_s = level_r;
        end
        // Occupancy after this edge plus the sample entering stage 1 now
        committed_s = {1'b0, level_nxt_s} + {{LW{1'b0}}, valid_in};
        ce_nxt_s    = en & (committed_s < CE_LIMIT);
    end

    // FIFO pointers, occupancy, status flags and registered ce
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            m_valid_r  <= 1'b0;
            ce_r       <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            level_r   <= level_nxt_s;
            m_valid_r <= (level_nxt_s != '0);
            ce_r      <= ce_nxt_s;
        end
    end

    // Sample storage; contents are meaningless while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= d1_r;
        end
    end

    assign ce        = ce_r;
    assign m.m_valid = m_valid_r;
    assign m.m_data  = mem_r[rd_ptr_r];
    assign level     = level_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_gng_scale_fifo.sv
// Self-checking bench for gng_scale_fifo: directed tables plus randomized
// traffic checked against a queue-based reference model.
module tb_gng_scale_fifo;

    localparam int DEPTH = 16;
    localparam int SLACK = 8;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [15:0] gain;
    logic        valid_in;
    logic [15:0] data_in;
    wire         ce;
    wire  [4:0]  level;
    wire         overflow;

    gng_scale_fifo_if m_if();

    gng_scale_fifo #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .gain     (gain),
        .ce       (ce),
        .valid_in (valid_in),
        .data_in  (data_in),
        .m        (m_if.master),
        .level    (level),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] q[$];
    bit          stg_v;
    logic [15:0] stg_d;
    bit          ovf_m;
    bit          ce_m;

    // Gain applied with plain integer arithmetic: floor((x*g + 8192) / 16384), clamped
    function automatic logic [15:0] model_scale(input logic [15:0] d, input logic [15:0] g);
        longint p, n, r;
        p = longint'($signed(d)) * longint'(g);
        n = p + 64'sd8192;
        if (n >= 0) r = n / 16384;
        else        r = -((-n + 16383) / 16384);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    task automatic model_reset();
        q.delete();
        stg_v = 1'b0;
        stg_d = 16'h0000;
        ovf_m = 1'b0;
        ce_m  = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, advance the model at the rising edge
    task automatic tick(input bit vin, input logic [15:0] din, input bit rdy);
        valid_in      = vin;
        data_in       = din;
        m_if.m_ready  = rdy;
        @(posedge clk);
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (stg_v) begin
            if (q.size() < DEPTH) q.push_back(stg_d);
            else                  ovf_m = 1'b1;
        end
        stg_v = vin;
        stg_d = model_scale(din, gain);
        ce_m  = en && ((DEPTH - (q.size() + int'(stg_v))) > SLACK);
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (ce !== 1'b0 || m_if.m_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_por ce=%b m_valid=%b level=%0d ovf=%b expected all 0",
                     ce, m_if.m_valid, level, overflow);
        end
        rstn = 1'b1;
        en   = 1'b1;
        gain = 16'd16384;
        for (int i = 0; i < 5; i++) tick(1'b1, 16'(i + 1), 1'b0);
        tick(1'b0, 16'h0000, 1'b0);
        checks++;
        if (level !== 5'd5) begin
            errors++;
            $display("FAIL reset_prefill level got %0d expected 5", level);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (ce !== 1'b0 || m_if.m_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_async ce=%b m_valid=%b level=%0d ovf=%b expected all 0",
                     ce, m_if.m_valid, level, overflow);
        end
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        tick(1'b1, 16'h0123, 1'b1);
        checks++;
        if (m_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_latency_t1 m_valid got %b expected 0", m_if.m_valid);
        end
        tick(1'b0, 16'h0000, 1'b0);
        checks++;
        if (m_if.m_valid !== 1'b1 || m_if.m_data !== 16'h0123) begin
            errors++;
            $display("FAIL reset_latency_t2 m_valid=%b m_data=%h expected 1/0123",
                     m_if.m_valid, m_if.m_data);
        end
        tick(1'b0, 16'h0000, 1'b1);
        checks++;
        if (m_if.m_valid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL reset_drain m_valid=%b level=%0d expected 0/0", m_if.m_valid, level);
        end
    endtask

    task automatic test_unity();
        logic [15:0] vec [4] = '{16'h0800, 16'h0001, 16'hFFFF, 16'h7FFF};
        gain = 16'd16384;
        for (int i = 0; i < 4; i++) tick(1'b1, vec[i], 1'b0);
        tick(1'b0, 16'h0000, 1'b0);
        checks++;
        if (level !== 5'd4) begin
            errors++;
            $display("FAIL unity_level got %0d expected 4", level);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_if.m_valid !== 1'b1 || m_if.m_data !== vec[i]) begin
                errors++;
                $display("FAIL unity_data[%0d] m_valid=%b m_data=%h expected 1/%h",
                         i, m_if.m_valid, m_if.m_data, vec[i]);
            end
            tick(1'b0, 16'h0000, 1'b1);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] vin  [4] = '{16'h0003, 16'hFFFD, 16'h0001, 16'hFFFF};
        logic [15:0] vexp [4] = '{16'h0002, 16'hFFFF, 16'h0001, 16'h0000};
        gain = 16'd8192;
        for (int i = 0; i < 4; i++) tick(1'b1, vin[i], 1'b0);
        tick(1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_if.m_valid !== 1'b1 || m_if.m_data !== vexp[i]) begin
                errors++;
                $display("FAIL round[%0d] in=%h m_valid=%b m_data=%h expected 1/%h",
                         i, vin[i], m_if.m_valid, m_if.m_data, vexp[i]);
            end
            tick(1'b0, 16'h0000, 1'b1);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] vin  [3] = '{16'h7000, 16'h8000, 16'h0000};
        logic [15:0] vexp [3] = '{16'h7FFF, 16'h8000, 16'h0000};
        gain = 16'hFFFF;
        for (int i = 0; i < 3; i++) tick(1'b1, vin[i], 1'b0);
        tick(1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_if.m_valid !== 1'b1 || m_if.m_data !== vexp[i]) begin
                errors++;
                $display("FAIL sat[%0d] in=%h m_valid=%b m_data=%h expected 1/%h",
                         i, vin[i], m_if.m_valid, m_if.m_data, vexp[i]);
            end
            tick(1'b0, 16'h0000, 1'b1);
        end
        checks++;
        if (m_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_empty m_valid got %b expected 0", m_if.m_valid);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        en = 1'b1;
        for (int seg = 0; seg < 4; seg++) begin
            gain = (seg == 0) ? 16'd16384 : 16'($urandom_range(0, 65535));
            for (int c = 0; c < 100; c++) begin
                case ($urandom_range(0, 7))
                    0:       d = 16'h7FFF;
                    1:       d = 16'h8000;
                    default: d = 16'($urandom);
                endcase
                tick(($urandom_range(0, 3) != 0) && ce, d, 1'($urandom_range(0, 1)));
                checks++;
                if (m_if.m_valid !== (q.size() != 0) || level !== 5'(q.size()) ||
                    ce !== ce_m || overflow !== ovf_m) begin
                    errors++;
                    $display("FAIL rand_status seg=%0d c=%0d m_valid=%b level=%0d ce=%b ovf=%b expected %b/%0d/%b/%b",
                             seg, c, m_if.m_valid, level, ce, overflow,
                             (q.size() != 0), q.size(), ce_m, ovf_m);
                end else if (q.size() != 0 && m_if.m_data !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data seg=%0d c=%0d m_data=%h expected %h",
                             seg, c, m_if.m_data, q[0]);
                end
            end
        end
        for (int c = 0; c < 24; c++) begin
            if (q.size() != 0) begin
                checks++;
                if (m_if.m_data !== q[0]) begin
                    errors++;
                    $display("FAIL rand_drain c=%0d m_data=%h expected %h", c, m_if.m_data, q[0]);
                end
            end
            tick(1'b0, 16'h0000, 1'b1);
        end
        checks++;
        if (level !== 5'd0 || m_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_empty level=%0d m_valid=%b expected 0/0", level, m_if.m_valid);
        end
    endtask

    task automatic test_backpressure();
        en   = 1'b1;
        gain = 16'd16384;
        for (int c = 0; c < 40; c++) begin
            tick(ce, 16'($urandom), 1'b0);
            checks++;
            if (level > 5'd16 || overflow !== 1'b0 || ce !== ce_m) begin
                errors++;
                $display("FAIL bp_fill c=%0d level=%0d ovf=%b ce=%b expected <=16/0/%b",
                         c, level, overflow, ce, ce_m);
            end
        end
        checks++;
        if (level !== 5'd8 || ce !== 1'b0) begin
            errors++;
            $display("FAIL bp_settle level=%0d ce=%b expected 8/0", level, ce);
        end
        for (int c = 0; c < 12; c++) begin
            if (q.size() != 0) begin
                checks++;
                if (m_if.m_data !== q[0]) begin
                    errors++;
                    $display("FAIL bp_drain c=%0d m_data=%h expected %h", c, m_if.m_data, q[0]);
                end
            end
            tick(1'b0, 16'h0000, 1'b1);
            checks++;
            if (ce !== ce_m) begin
                errors++;
                $display("FAIL bp_ce c=%0d ce=%b expected %b", c, ce, ce_m);
            end
        end
        checks++;
        if (m_if.m_valid !== 1'b0 || ce !== 1'b1) begin
            errors++;
            $display("FAIL bp_end m_valid=%b ce=%b expected 0/1", m_if.m_valid, ce);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] sent [17];
        en   = 1'b0;
        gain = 16'd16384;
        // Fill to exactly full, then push and pop in the same cycle
        for (int i = 0; i < 16; i++) tick(1'b1, 16'($urandom), 1'b0);
        tick(1'b0, 16'h0000, 1'b0);
        checks++;
        if (level !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full level=%0d ovf=%b expected 16/0", level, overflow);
        end
        tick(1'b1, 16'h5A5A, 1'b0);
        tick(1'b0, 16'h0000, 1'b1);
        checks++;
        if (level !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pushpop level=%0d ovf=%b expected 16/0", level, overflow);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (m_if.m_valid !== 1'b1 || m_if.m_data !== q[0]) begin
                errors++;
                $display("FAIL ovf_drain1[%0d] m_valid=%b m_data=%h expected 1/%h",
                         i, m_if.m_valid, m_if.m_data, q[0]);
            end
            tick(1'b0, 16'h0000, 1'b1);
        end
        // Seventeen back-to-back samples into an empty FIFO with no reader
        for (int i = 0; i < 17; i++) begin
            sent[i] = 16'($urandom);
            tick(1'b1, sent[i], 1'b0);
        end
        tick(1'b0, 16'h0000, 1'b0);
        checks++;
        if (level !== 5'd16 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set level=%0d ovf=%b expected 16/1", level, overflow);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (m_if.m_valid !== 1'b1 || m_if.m_data !== sent[i]) begin
                errors++;
                $display("FAIL ovf_drain2[%0d] m_valid=%b m_data=%h expected 1/%h",
                         i, m_if.m_valid, m_if.m_data, sent[i]);
            end
            tick(1'b0, 16'h0000, 1'b1);
        end
        checks++;
        if (m_if.m_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_end m_valid=%b level=%0d ovf=%b expected 0/0/1",
                     m_if.m_valid, level, overflow);
        end
    endtask

    initial begin
        rstn         = 1'b0;
        en           = 1'b0;
        gain         = 16'd16384;
        valid_in     = 1'b0;
        data_in      = 16'h0000;
        m_if.m_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_unity();
        test_rounding();
        test_saturation();
        test_random();
        test_backpressure();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
